ex_stage: RTL

- Execute stage of the 5-stage 16-bit pipeline; sits directly downstream of the decode/operand stage.
- Consumes ex_ir, reg_A, reg_B and smdr from decode.
- Computes the ALU result, memory address and branch target, and holds the ZF/NF/CF flag register.
- Resolves conditional branches and JMPR, and raises jump to the fetch stage and decode (flush).
- Registers mem_ir, reg_C, smdr1 and dw into the memory stage.

---
 rtl/ex_stage_pkg.sv | 53 +++++
 rtl/ex_stage_alu.sv | 45 ++++
 rtl/ex_stage.sv | 90 +++++++++
 3 files changed

// File: rtl/ex_stage_pkg.sv
// Shared opcode map, run-state encoding and flag-update classification
// for the 16-bit pipeline execute stage.
package ex_stage_pkg;

  localparam logic EXEC = 1'b1;
  localparam logic IDLE = 1'b0;

  localparam logic [4:0] OP_NOP   = 5'b00000;
  localparam logic [4:0] OP_HALT  = 5'b00001;
  localparam logic [4:0] OP_LOAD  = 5'b00010;
  localparam logic [4:0] OP_STORE = 5'b00011;
  localparam logic [4:0] OP_SLL   = 5'b00100;
  localparam logic [4:0] OP_SLA   = 5'b00101;
  localparam logic [4:0] OP_SRL   = 5'b00110;
  localparam logic [4:0] OP_SRA   = 5'b00111;
  localparam logic [4:0] OP_ADD   = 5'b01000;
  localparam logic [4:0] OP_ADDI  = 5'b01001;
  localparam logic [4:0] OP_SUB   = 5'b01010;
  localparam logic [4:0] OP_SUBI  = 5'b01011;
  localparam logic [4:0] OP_CMP   = 5'b01100;
  localparam logic [4:0] OP_AND   = 5'b01101;
  localparam logic [4:0] OP_OR    = 5'b01110;
  localparam logic [4:0] OP_XOR   = 5'b01111;
  localparam logic [4:0] OP_LDIH  = 5'b10000;
  localparam logic [4:0] OP_ADDC  = 5'b10001;
  localparam logic [4:0] OP_SUBC  = 5'b10010;
  localparam logic [4:0] OP_JUMP  = 5'b11000;
  localparam logic [4:0] OP_JMPR  = 5'b11001;
  localparam logic [4:0] OP_BZ    = 5'b11010;
  localparam logic [4:0] OP_BNZ   = 5'b11011;
  localparam logic [4:0] OP_BN    = 5'b11100;
  localparam logic [4:0] OP_BNN   = 5'b11101;
  localparam logic [4:0] OP_BC    = 5'b11110;
  localparam logic [4:0] OP_BNC   = 5'b11111;

  typedef enum logic [1:0] {
    FC_NONE,
    FC_ARITH,
    FC_LOGIC
  } flag_class_e;

  function automatic flag_class_e flag_class(input logic [4:0] op);
    case (op)
      OP_ADD, OP_ADDI, OP_ADDC, OP_SUB, OP_SUBI, OP_SUBC, OP_CMP, OP_LDIH:
        return FC_ARITH;
      OP_AND, OP_OR, OP_XOR, OP_SLL, OP_SLA, OP_SRL, OP_SRA:
        return FC_LOGIC;
      default:
        return FC_NONE;
    endcase
  endfunction

endpackage

// File: rtl/ex_stage_alu.sv
// Combinational ALU for the execute stage; a 17-bit internal result gives
// carry-out on adds and borrow on subtracts through the same top bit.
module ex_alu
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 5
) (
  input  logic [OPW-1:0]   op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] result,
  output logic             cout
);

  logic [WIDTH:0]   wide;
  logic [WIDTH-1:0] sra_val;

  assign sra_val = $unsigned($signed(a) >>> b[3:0]);

  always_comb begin
    wide = '0;
    case (op)
      OP_ADD, OP_ADDI, OP_LDIH, OP_LOAD, OP_STORE, OP_JMPR,
      OP_BZ, OP_BNZ, OP_BN, OP_BNN, OP_BC, OP_BNC:
        wide = {1'b0, a} + {1'b0, b};
      OP_ADDC: wide = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
      OP_SUB, OP_SUBI, OP_CMP:
        wide = {1'b0, a} - {1'b0, b};
      OP_SUBC: wide = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};
      OP_AND:  wide = {1'b0, a & b};
      OP_OR:   wide = {1'b0, a | b};
      OP_XOR:  wide = {1'b0, a ^ b};
      OP_SLL, OP_SLA: wide = {1'b0, a << b[3:0]};
      OP_SRL:  wide = {1'b0, a >> b[3:0]};
      OP_SRA:  wide = {1'b0, sra_val};
      default: wide = '0;
    endcase
  end

  assign result = wide[WIDTH-1:0];
  assign cout   = wide[WIDTH];

endmodule

// File: rtl/ex_stage.sv
// Execute stage: ALU, ZF/NF/CF flag register, branch resolution and the
// EX->MEM pipeline register. Everything stateful freezes outside EXEC.
module ex_stage
  import ex_stage_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int OPW   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             state,
  input  logic [WIDTH-1:0] ex_ir,
  input  logic [WIDTH-1:0] reg_A,
  input  logic [WIDTH-1:0] reg_B,
  input  logic [WIDTH-1:0] smdr,
  output logic [WIDTH-1:0] ALUo,
  output logic             jump,
  output logic [WIDTH-1:0] mem_ir,
  output logic [WIDTH-1:0] reg_C,
  output logic [WIDTH-1:0] smdr1,
  output logic             dw,
  output logic             zf,
  output logic             nf,
  output logic             cf
);

  logic [OPW-1:0] op;
  logic           exec_en;
  logic           alu_cout;
  logic           take;

  assign op      = ex_ir[WIDTH-1 -: OPW];
  assign exec_en = (state == EXEC);

  ex_alu #(.WIDTH(WIDTH), .OPW(OPW)) u_alu (
    .op     (op),
    .a      (reg_A),
    .b      (reg_B),
    .cin    (cf),
    .result (ALUo),
    .cout   (alu_cout)
  );

  // Branches read the registered flags; the producer is always a cycle ahead.
  always_comb begin
    take = 1'b0;
    case (op)
      OP_JMPR: take = 1'b1;
      OP_BZ:   take = zf;
      OP_BNZ:  take = ~zf;
      OP_BN:   take = nf;
      OP_BNN:  take = ~nf;
      OP_BC:   take = cf;
      OP_BNC:  take = ~cf;
      default: take = 1'b0;
    endcase
  end

  assign jump = take & exec_en;

  always_ff @(posedge clock) begin
    if (reset) begin
      mem_ir <= '0;
      reg_C  <= '0;
      smdr1  <= '0;
      dw     <= 1'b0;
      zf     <= 1'b0;
      nf     <= 1'b0;
      cf     <= 1'b0;
    end else if (exec_en) begin
      mem_ir <= ex_ir;
      reg_C  <= ALUo;
      smdr1  <= smdr;
      dw     <= (op == OP_STORE);
      case (flag_class(op))
        FC_ARITH: begin
          zf <= (ALUo == '0);
          nf <= ALUo[WIDTH-1];
          cf <= alu_cout;
        end
        FC_LOGIC: begin
          zf <= (ALUo == '0);
          nf <= ALUo[WIDTH-1];
        end
        default: ;
      endcase
    end
  end

endmodule
